// File: rtl/mac_tx_pkg.sv
// mac_tx_pkg: state and source encodings shared by the TX scheduler and its selector
package mac_tx_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WAIT_END, ST_GAP} state_t;
   localparam int SRC_ARP_REPLY   = 0;
   localparam int SRC_ARP_REQUEST = 1;
   localparam int SRC_ICMP        = 2;
   localparam int SRC_UDP         = 3;
endpackage

// File: rtl/mac_tx_prio_sel.sv
// mac_tx_prio_sel: one-hot fixed-priority pick with UDP boost override
module mac_tx_prio_sel
   import mac_tx_pkg::*;
(
   input  logic [3:0] pending_i,
   input  logic       boost_i,
   output logic [3:0] select_o
);
   localparam logic [3:0] ONE = 4'd1;
   always_comb
      select_o = (boost_i && pending_i[SRC_UDP]) ? ONE << SRC_UDP :
                 pending_i[SRC_ARP_REPLY]        ? ONE << SRC_ARP_REPLY :
                 pending_i[SRC_ICMP]             ? ONE << SRC_ICMP :
                 pending_i[SRC_ARP_REQUEST]      ? ONE << SRC_ARP_REQUEST :
                 pending_i[SRC_UDP]              ? ONE << SRC_UDP : 4'd0;
endmodule

// File: rtl/mac_tx_scheduler.sv
// mac_tx_scheduler: serialises ARP/ICMP/UDP frame requests onto one MAC TX path with gap and watchdog
module mac_tx_scheduler
   import mac_tx_pkg::*;
#(
   parameter int          IFG_CYCLES     = 12,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd4000,
   parameter int          MAX_DEFER      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arp_reply_in,
   input  logic       arp_request_in,
   input  logic       icmp_req_in,
   input  logic       udp_req_in,
   input  logic       mac_send_end,
   output logic       arp_reply_req,
   output logic       arp_request_req,
   output logic       icmp_tx_req,
   output logic       udp_tx_req,
   output logic [3:0] pending,
   output logic       busy,
   output logic       timeout_err
);
   localparam int            DW        = ($clog2(MAX_DEFER + 1) < 2) ? 2 : $clog2(MAX_DEFER + 1);
   localparam logic [DW-1:0] DEFER_MAX = DW'(MAX_DEFER);
   localparam logic [15:0]   GAP_LAST  = 16'(IFG_CYCLES - 1);
   localparam logic [15:0]   TMO_LAST  = TIMEOUT_CYCLES - 16'd1;
   state_t        state_q, state_d;
   logic [3:0]    pend_q, pend_d, sel_q, sel_d, sel, req, grant;
   logic [15:0]   cnt_q, cnt_d;
   logic [DW-1:0] defer_q, defer_d;
   logic          tmo_q, tmo_d, boost;
   assign boost = defer_q == DEFER_MAX;
   mac_tx_prio_sel u_sel (.pending_i(pend_q), .boost_i(boost), .select_o(sel));
   assign req   = {udp_req_in, icmp_req_in, arp_request_in, arp_reply_in};
   assign grant = (state_q == ST_GRANT) ? sel_q : 4'd0;
   assign {udp_tx_req, icmp_tx_req, arp_request_req, arp_reply_req} = grant;
   assign pending     = pend_q;
   assign busy        = state_q != ST_IDLE;
   assign timeout_err = tmo_q;
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      tmo_d   = 1'b0;
      pend_d  = (pend_q & ~grant) | req;
      defer_d = (!pend_q[SRC_UDP] || grant[SRC_UDP]) ? '0 :
                (|grant && defer_q != DEFER_MAX)     ? defer_q + 1'b1 : defer_q;
      unique case (state_q)
         ST_IDLE:
            if (|pend_q) begin
               state_d = ST_GRANT;
               sel_d   = sel;
            end
         ST_GRANT: state_d = ST_WAIT_END;
         // a completion in the final watchdog cycle still counts as a clean finish
         ST_WAIT_END:
            if (mac_send_end || cnt_q == TMO_LAST) begin
               tmo_d   = !mac_send_end;
               cnt_d   = '0;
               state_d = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else
               cnt_d = cnt_q + 16'd1;
         ST_GAP:
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else
               cnt_d = cnt_q + 16'd1;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         defer_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         defer_q <= defer_d;
         tmo_q   <= tmo_d;
      end
endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb_mac_tx_scheduler: directed scenarios plus a randomized frame-level reference model
module tb_mac_tx_scheduler;
   localparam int IFG  = 12;
   localparam int TMO  = 100;
   localparam int MAXD = 3;
   logic clk = 1'b0, rst = 1'b1;
   logic arp_reply_in = 1'b0, arp_request_in = 1'b0, icmp_req_in = 1'b0, udp_req_in = 1'b0, mac_send_end = 1'b0;
   logic arp_reply_req, arp_request_req, icmp_tx_req, udp_tx_req, busy, timeout_err;
   logic [3:0] pending, gnt;
   int checks = 0, failures = 0;
   assign gnt = {udp_tx_req, icmp_tx_req, arp_request_req, arp_reply_req};
   always #5 clk = ~clk;

   mac_tx_scheduler #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(16'(TMO)), .MAX_DEFER(MAXD)) dut (
      .clk(clk), .rst(rst),
      .arp_reply_in(arp_reply_in), .arp_request_in(arp_request_in),
      .icmp_req_in(icmp_req_in), .udp_req_in(udp_req_in), .mac_send_end(mac_send_end),
      .arp_reply_req(arp_reply_req), .arp_request_req(arp_request_req),
      .icmp_tx_req(icmp_tx_req), .udp_tx_req(udp_tx_req),
      .pending(pending), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic drive(input logic [3:0] r, input logic e);
      {udp_req_in, icmp_req_in, arp_request_in, arp_reply_in} = r;
      mac_send_end = e;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [3:0] p, input bit boost);
      int order[4] = '{0, 2, 1, 3};
      if (boost && p[3]) return 3;
      foreach (order[i]) if (p[order[i]]) return order[i];
      return -1;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      drive(4'd0, 1'b0);
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({gnt, pending, busy, timeout_err} !== 10'd0) begin
            failures++;
            $display("FAIL reset i=%0d got=%b exp=0", i, {gnt, pending, busy, timeout_err});
         end
         rst = 1'b0;
         tick();
      end
   endtask

   task automatic test_single();
      for (int c = 0; c <= 60; c++) begin
         logic [3:0] eg;
         eg = (c == 2) ? 4'b1000 : 4'b0000;
         checks++;
         if (gnt !== eg) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, gnt, eg); end
         checks++;
         if (busy !== (c >= 2 && c <= 42)) begin failures++; $display("FAIL single_busy c=%0d got=%b", c, busy); end
         if (c == 1 || c == 3) begin
            checks++;
            if (pending !== ((c == 1) ? 4'b1000 : 4'b0000)) begin failures++; $display("FAIL single_pending c=%0d got=%b", c, pending); end
         end
         drive((c == 0) ? 4'b1000 : 4'b0000, c == 30);
         tick();
      end
   endtask

   // grants spaced by 20-cycle frames + IFG + GRANT + IDLE
   task automatic test_simultaneous();
      int gc[4] = '{2, 36, 70, 104};
      logic [3:0] gs[4] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
      for (int c = 0; c <= 150; c++) begin
         logic [3:0] eg;
         logic e;
         eg = 4'd0;
         e = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (c == gc[k]) eg = gs[k];
            if (c == gc[k] + 20) e = 1'b1;
         end
         checks++;
         if (gnt !== eg) begin failures++; $display("FAIL simul_grant c=%0d got=%b exp=%b", c, gnt, eg); end
         if (c == 1 || c == 3) begin
            checks++;
            if (pending !== ((c == 1) ? 4'b1111 : 4'b1110)) begin failures++; $display("FAIL simul_pending c=%0d got=%b", c, pending); end
         end
         drive((c == 0) ? 4'b1111 : 4'b0000, e);
         tick();
      end
      checks++;
      if ({pending, busy} !== 5'd0) begin failures++; $display("FAIL simul_drain got=%b exp=0", {pending, busy}); end
   endtask

   task automatic test_starvation();
      int gc[5] = '{2, 36, 70, 104, 138};
      logic [3:0] gs[5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0100};
      for (int c = 0; c <= 185; c++) begin
         logic [3:0] eg, r;
         logic e;
         eg = 4'd0;
         r = (c == 0) ? 4'b1100 : 4'b0000;
         e = 1'b0;
         for (int k = 0; k < 5; k++) begin
            if (c == gc[k]) eg = gs[k];
            if (k < 4 && c == gc[k] + 5) r = 4'b0100;
            if (c == gc[k] + 20) e = 1'b1;
         end
         checks++;
         if (gnt !== eg) begin failures++; $display("FAIL starve_grant c=%0d got=%b exp=%b", c, gnt, eg); end
         drive(r, e);
         tick();
      end
      checks++;
      if ({pending, busy} !== 5'd0) begin failures++; $display("FAIL starve_drain got=%b exp=0", {pending, busy}); end
   endtask

   // first frame times out; second frame completes exactly on the last watchdog cycle
   task automatic test_watchdog();
      for (int c = 0; c <= 240; c++) begin
         logic [3:0] eg;
         eg = (c == 2) ? 4'b0010 : (c == 116) ? 4'b0001 : 4'b0000;
         checks++;
         if (gnt !== eg) begin failures++; $display("FAIL wdog_grant c=%0d got=%b exp=%b", c, gnt, eg); end
         checks++;
         if (timeout_err !== (c == 103)) begin failures++; $display("FAIL wdog_timeout c=%0d got=%b", c, timeout_err); end
         checks++;
         if (busy !== ((c >= 2 && c <= 114) || (c >= 116 && c <= 228))) begin failures++; $display("FAIL wdog_busy c=%0d got=%b", c, busy); end
         drive((c == 0) ? 4'b0010 : (c == 50) ? 4'b0001 : 4'b0000, c == 216);
         tick();
      end
   endtask

   task automatic test_repulse();
      for (int c = 0; c <= 50; c++) begin
         logic [3:0] eg;
         eg = (c == 2 || c == 24) ? 4'b0100 : 4'b0000;
         checks++;
         if (gnt !== eg) begin failures++; $display("FAIL repulse_grant c=%0d got=%b exp=%b", c, gnt, eg); end
         if (c == 3 || c == 50) begin
            checks++;
            if (pending !== ((c == 3) ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL repulse_pending c=%0d got=%b", c, pending); end
         end
         drive((c == 0 || c == 2) ? 4'b0100 : 4'b0000, c == 10 || c == 30);
         tick();
      end
   endtask

   task automatic test_stray();
      for (int c = 0; c < 8; c++) begin
         checks++;
         if ({gnt, pending, busy, timeout_err} !== 10'd0) begin
            failures++;
            $display("FAIL stray_end c=%0d got=%b exp=0", c, {gnt, pending, busy, timeout_err});
         end
         drive(4'd0, c < 4);
         tick();
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c <= 170; c++) begin
         if (c == 2) begin
            checks++;
            if (gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_grant got=%b exp=0001", gnt); end
         end
         if (c == 6) begin
            checks++;
            if (pending !== 4'b1010) begin failures++; $display("FAIL rstmid_pending got=%b exp=1010", pending); end
         end
         if (c >= 11) begin
            checks++;
            if ({gnt, pending, busy, timeout_err} !== 10'd0) begin
               failures++;
               $display("FAIL rstmid_quiet c=%0d got=%b exp=0", c, {gnt, pending, busy, timeout_err});
            end
         end
         rst = (c == 10);
         drive((c == 0) ? 4'b0001 : (c == 5) ? 4'b1010 : 4'b0000, 1'b0);
         tick();
      end
      rst = 1'b0;
   endtask

   // frame-level model: pending set, defer count, frame windows and gap arithmetic
   task automatic test_random();
      logic [3:0] mp, last_pend, req, gv;
      bit in_frame, last_idle, endin;
      int g, e, idle_from, defer, src;
      mp = 4'd0; last_pend = 4'd0; in_frame = 0; last_idle = 1; idle_from = 0; defer = 0; g = 0; e = 0;
      for (int c = 0; c < 2000; c++) begin
         gv = 4'd0;
         if (last_idle && last_pend != 4'd0) begin
            src = pick(last_pend, defer == MAXD);
            gv = 4'b0001 << src;
            in_frame = 1;
            g = c;
            e = c + int'($urandom_range(1, 25));
         end
         checks++;
         if (gnt !== gv) begin failures++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, gnt, gv); end
         checks++;
         if (pending !== mp) begin failures++; $display("FAIL rand_pending c=%0d got=%b exp=%b", c, pending, mp); end
         checks++;
         if (busy !== (in_frame || c < idle_from)) begin failures++; $display("FAIL rand_busy c=%0d got=%b", c, busy); end
         checks++;
         if (timeout_err !== 1'b0) begin failures++; $display("FAIL rand_timeout c=%0d got=%b exp=0", c, timeout_err); end
         for (int i = 0; i < 4; i++) req[i] = (c < 1500) && ($urandom_range(0, 11) == 0);
         endin = (in_frame && c == e) || (!(in_frame && c > g) && $urandom_range(0, 7) == 0);
         drive(req, endin);
         tick();
         if (!mp[3] || gv[3]) defer = 0;
         else if (gv != 4'd0 && defer < MAXD) defer++;
         last_idle = !in_frame && c >= idle_from;
         last_pend = mp;
         mp = (mp & ~gv) | req;
         if (in_frame && c == e) begin
            in_frame = 0;
            idle_from = e + IFG + 1;
         end
      end
      checks++;
      if ({pending, busy} !== 5'd0) begin failures++; $display("FAIL rand_drain got=%b exp=0", {pending, busy}); end
   endtask

   initial begin
      #2000000;
      $display("FAIL sim_timeout bench did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_starvation();
      test_watchdog();
      test_repulse();
      test_stray();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
